// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared types and address constants for the sound register bus
package sound_pkg;

  // Aux transfer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  // Sound block decode points; BUS_IDLE_ADDR sits outside every decode
  localparam logic [15:0] POKEY_BZ_BASE = 16'h1820;
  localparam logic [15:0] POKEY_RB_BASE = 16'h1810;
  localparam logic [15:0] OUTLATCH_A    = 16'h1840;
  localparam logic [15:0] OUTLATCH_B    = 16'h1808;
  localparam logic [15:0] BUS_IDLE_ADDR = 16'h0000;

  // Inclusive window check used to gate aux requests
  function automatic logic addr_in_range(input logic [15:0] addr,
                                         input logic [15:0] lo,
                                         input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/sound_bus_arbiter.sv
// rtl/sound_bus_arbiter.sv - CPU-priority arbiter sharing the sound bus with an aux requester
module sound_bus_arbiter
  import sound_pkg::*;
#(
  parameter logic [7:0]  TIMEOUT_SLOTS = 8'd255,
  parameter logic [15:0] AUX_ADDR_LO   = 16'h1800,
  parameter logic [15:0] AUX_ADDR_HI   = 16'h184F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_3MHz_en,
  input  logic        cpu_sel,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic        aux_ack,
  output logic        aux_err,
  output logic [7:0]  aux_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  input  logic [7:0]  bus_rdata,
  output logic        aux_busy
);

  arb_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        lat_we_q, lat_we_d;
  logic [15:0] lat_addr_q, lat_addr_d;
  logic [7:0]  lat_wdata_q, lat_wdata_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        bus_rd_q, bus_rd_d;
  logic        cpu_rd_slot_q, cpu_rd_slot_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  aux_rdata_q, aux_rdata_d;
  logic        aux_ack_q, aux_ack_d;
  logic        aux_err_q, aux_err_d;

  // Saturating increment of the lost-slot counter
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Slot ownership, CPU read-back and aux FSM next-state
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_we_d      = lat_we_q;
    lat_addr_d    = lat_addr_q;
    lat_wdata_d   = lat_wdata_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_rd_d      = bus_rd_q;
    cpu_rd_slot_d = cpu_rd_slot_q;
    cpu_rdata_d   = cpu_rdata_q;
    aux_rdata_d   = aux_rdata_q;
    aux_ack_d     = 1'b0;
    aux_err_d     = 1'b0;

    if (clk_3MHz_en) begin
      // Read data for the slot that just ended belongs to the CPU if it read
      if (cpu_rd_slot_q) begin
        cpu_rdata_d = bus_rdata;
      end
      cpu_rd_slot_d = cpu_sel & ~cpu_we;

      if (cpu_sel) begin
        bus_addr_d  = cpu_addr;
        bus_wdata_d = cpu_wdata;
        bus_rd_d    = ~cpu_we;
      end else if ((state_q == WAIT) && aux_req) begin
        bus_addr_d  = lat_addr_q;
        bus_wdata_d = lat_wdata_q;
        bus_rd_d    = ~lat_we_q;
      end else begin
        bus_addr_d  = BUS_IDLE_ADDR;
        bus_wdata_d = 8'h00;
        bus_rd_d    = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // Ignore the request during the err pulse so one bad request gives one error
        if (aux_req && !aux_err_q) begin
          if (addr_in_range(aux_addr, AUX_ADDR_LO, AUX_ADDR_HI)) begin
            lat_we_d    = aux_we;
            lat_addr_d  = aux_addr;
            lat_wdata_d = aux_wdata;
            cnt_d       = 8'd0;
            state_d     = WAIT;
          end else begin
            aux_err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!aux_req) begin
          state_d = IDLE;
        end else if (clk_3MHz_en) begin
          if (cpu_sel) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= TIMEOUT_SLOTS) begin
              aux_err_d = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (clk_3MHz_en) begin
          aux_rdata_d = bus_rdata;
          aux_ack_d   = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (!aux_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset parks the bus on an idle read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      lat_we_q      <= 1'b0;
      lat_addr_q    <= 16'h0000;
      lat_wdata_q   <= 8'h00;
      bus_addr_q    <= BUS_IDLE_ADDR;
      bus_wdata_q   <= 8'h00;
      bus_rd_q      <= 1'b1;
      cpu_rd_slot_q <= 1'b0;
      cpu_rdata_q   <= 8'h00;
      aux_rdata_q   <= 8'h00;
      aux_ack_q     <= 1'b0;
      aux_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_we_q      <= lat_we_d;
      lat_addr_q    <= lat_addr_d;
      lat_wdata_q   <= lat_wdata_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_rd_q      <= bus_rd_d;
      cpu_rd_slot_q <= cpu_rd_slot_d;
      cpu_rdata_q   <= cpu_rdata_d;
      aux_rdata_q   <= aux_rdata_d;
      aux_ack_q     <= aux_ack_d;
      aux_err_q     <= aux_err_d;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_rd    = bus_rd_q;
  assign cpu_rdata = cpu_rdata_q;
  assign aux_rdata = aux_rdata_q;
  assign aux_ack   = aux_ack_q;
  assign aux_err   = aux_err_q;
  assign aux_busy  = (state_q != IDLE);

endmodule
